// File: rtl/i2s_pkg.sv
// i2s_pkg: I2S frame geometry constants and the sequencer state type shared by the DAC sequencer files
package i2s_pkg;
  localparam int I2S_SLOT_BITS = 16;
  localparam int I2S_FRAME_BITS = 32;
  localparam int I2S_SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: free-running mclk divider plus run-gated sclk divider (sysclk/reset/run in; mclk, sclk, one-cycle sclk_fall strobe out)
module i2s_clk_gen #(
  parameter int SCLK_HALF = 7,
  parameter int MCLK_HALF = 1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run,
  output logic mclk,
  output logic sclk,
  output logic sclk_fall
);
  logic [3:0] mcnt;
  logic [7:0] scnt;
  logic mwrap, swrap;
  always_comb begin
    mwrap = mcnt == 4'(MCLK_HALF - 1);
    swrap = scnt == 8'(SCLK_HALF - 1);
    sclk_fall = run && sclk && swrap;
  end
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      mcnt <= '0;
      mclk <= 1'b0;
      scnt <= '0;
      sclk <= 1'b0;
    end else begin
      mcnt <= mwrap ? '0 : mcnt + 4'd1;
      mclk <= mclk ^ mwrap;
      scnt <= run && !swrap ? scnt + 8'd1 : '0;
      sclk <= run && (sclk ^ swrap);
    end
  end
endmodule

// File: rtl/i2s_dac_sequencer.sv
// i2s_dac_sequencer: I2S DAC sequencer (sysclk/reset, enable, sample_l/sample_r/sample_valid in; sample_ready/underrun handshake, mclk/sclk/lrclk/sdin pins, busy out)
module i2s_dac_sequencer
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF = 7,
  parameter int MCLK_HALF = 1
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [I2S_SAMPLE_W-1:0] sample_l,
  input  logic [I2S_SAMPLE_W-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    underrun,
  output logic                    mclk,
  output logic                    sclk,
  output logic                    lrclk,
  output logic                    sdin,
  output logic                    busy
);
  state_t state, state_n;
  logic [4:0] k;
  logic [I2S_FRAME_BITS-1:0] shreg;
  logic [I2S_SAMPLE_W-1:0] hold_l, hold_r;
  logic fall, wrap, last;
  i2s_clk_gen #(
    .SCLK_HALF(SCLK_HALF),
    .MCLK_HALF(MCLK_HALF)
  ) u_clk (
    .sysclk(sysclk),
    .reset(reset),
    .run(busy),
    .mclk(mclk),
    .sclk(sclk),
    .sclk_fall(fall)
  );
  // last marks the extra slot after a stop that carries the final R[0] before going idle
  always_comb begin
    busy = state != IDLE;
    wrap = fall && k == 5'(I2S_FRAME_BITS - 1);
    sample_ready = state == LOAD || (state == SHIFT && wrap && enable && !last);
    underrun = sample_ready && !sample_valid;
    lrclk = k >= 5'(I2S_SLOT_BITS);
    state_n = state == IDLE ? (enable ? LOAD : IDLE) :
              state == LOAD ? SHIFT :
              fall && last ? IDLE : SHIFT;
  end
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // the shifter's top bit is always the next sdin value, so a boundary reload still emits the old R[0]
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      k <= '0;
      shreg <= '0;
      hold_l <= '0;
      hold_r <= '0;
      sdin <= 1'b0;
      last <= 1'b0;
    end else begin
      if (sample_ready && sample_valid) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
      if (sample_ready)
        shreg <= sample_valid ? {sample_l, sample_r} : {hold_l, hold_r};
      else if (fall)
        shreg <= shreg << 1;
      if (fall) begin
        k <= last ? '0 : k + 5'd1;
        sdin <= !last && shreg[I2S_FRAME_BITS-1];
        last <= !last && wrap && !enable;
      end
    end
  end
endmodule
